aes_encrypt128_iter: RTL and testbench

//  Iterative AES-128 encryptor; the encrypt-side counterpart of the AES-128 decryption path.

---
 rtl/aes_pkg.sv | 98 +++++++++
 rtl/aes_encrypt128_iter_if.sv | 16 +
 rtl/aes_enc_round.sv | 21 ++
 rtl/aes_encrypt128_iter.sv | 130 +++++++++++++
 tb/tb_aes_encrypt128_iter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 encryption primitives shared by the iterative encryptor.
// Contents: state_t FSM encoding, S-box and round-constant tables, and the
// byte/word/state transforms used by one encryption round plus the forward
// key-schedule step. A 128-bit state maps FIPS-197 byte k to bits [127-8k -: 8],
// and bytes are column-major (byte r + 4c is row r, column c).
package aes_pkg;

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NR     = 10;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [BYTE_W-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [BYTE_W-1:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        logic [BYTE_W-1:0] a0, a1, a2, a3;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // Derive the next round key from the current one (forward schedule).
    function automatic logic [BLK_W-1:0] key_step(input logic [BLK_W-1:0] rk,
                                                  input logic [BYTE_W-1:0] rc);
        logic [WORD_W-1:0] t, n0, n1, n2, n3;
        t  = sub_word(rot_word(rk[31:0])) ^ {rc, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64]  ^ n0;
        n2 = rk[63:32]  ^ n1;
        n3 = rk[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_encrypt128_iter_if.sv
// Key/plaintext/ciphertext handshake bundle of the AES-128 encryptor.
// master: key and plaintext source, ciphertext sink. slave: the encryptor.
// All data fields are [0:127]: bit 0 is the MSB of byte 0.
interface aes_encrypt128_iter_if;
    logic [0:127] kt;
    logic         kt_vld;
    logic         kt_rdy;
    logic [0:127] pt;
    logic         pt_vld;
    logic         pt_rdy;
    logic [0:127] ct;
    logic         ct_vld;

    modport master (output kt, kt_vld, pt, pt_vld, input kt_rdy, pt_rdy, ct, ct_vld);
    modport slave  (input kt, kt_vld, pt, pt_vld, output kt_rdy, pt_rdy, ct, ct_vld);
endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES-128 encryption round with its key-schedule step.
// Ports: st/rk current state and round key, rcon for this round, last drops
// MixColumns (round 10); st_next/rk_next are the round outputs.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0]  st,
    input  logic [BLK_W-1:0]  rk,
    input  logic [BYTE_W-1:0] rcon,
    input  logic              last,
    output logic [BLK_W-1:0]  st_next,
    output logic [BLK_W-1:0]  rk_next
);

    logic [BLK_W-1:0] sr;

    assign rk_next = key_step(rk, rcon);
    assign sr      = shift_rows(sub_bytes(st));
    assign st_next = (last ? sr : mix_columns(sr)) ^ rk_next;

endmodule

// File: rtl/aes_encrypt128_iter.sv
// Iterative AES-128 encryptor with on-the-fly forward key expansion.
// Ports: clk, rst (synchronous, active-high), bus (slave side of the
// key/plaintext/ciphertext handshake). ROUNDS_PER_CYCLE (1 or 2) sets how
// many rounds are chained per clock; a block takes 10/ROUNDS_PER_CYCLE edges.
module aes_encrypt128_iter
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_encrypt128_iter_if.slave bus
);

    localparam int unsigned NRC   = NR / ROUNDS_PER_CYCLE;
    localparam int unsigned RND_W = 4;

    state_t             state, state_d;
    logic               key_loaded, key_loaded_d;
    logic [BLK_W-1:0]   key_reg, key_reg_d;
    logic [BLK_W-1:0]   st, st_d;
    logic [BLK_W-1:0]   rk, rk_d;
    logic [BLK_W-1:0]   ct_q, ct_d;
    logic               ct_vld_q, ct_vld_d;
    logic [RND_W-1:0]   rnd, rnd_d;
    logic               kt_rdy_c, pt_rdy_c;
    logic [RND_W-1:0]   idx0;
    logic [BLK_W-1:0]   st_r0, rk_r0, st_r1, rk_r1;

    // A pending key blocks plaintext so the block always sees the newest key.
    assign kt_rdy_c   = !rst && (state == IDLE);
    assign pt_rdy_c   = kt_rdy_c && key_loaded && !bus.kt_vld;
    assign bus.kt_rdy = kt_rdy_c;
    assign bus.pt_rdy = pt_rdy_c;
    assign bus.ct     = ct_q;
    assign bus.ct_vld = ct_vld_q;

    // Zero-based absolute index of the first round computed this edge.
    assign idx0 = RND_W'(rnd * ROUNDS_PER_CYCLE);

    aes_enc_round u_round0 (
        .st      (st),
        .rk      (rk),
        .rcon    (RCON[idx0]),
        .last    (idx0 == 4'd9),
        .st_next (st_r0),
        .rk_next (rk_r0)
    );

    generate
        if (ROUNDS_PER_CYCLE == 2) begin : g_two
            logic [RND_W-1:0] idx1;
            assign idx1 = idx0 + 4'd1;
            aes_enc_round u_round1 (
                .st      (st_r0),
                .rk      (rk_r0),
                .rcon    (RCON[idx1]),
                .last    (idx1 == 4'd9),
                .st_next (st_r1),
                .rk_next (rk_r1)
            );
        end else begin : g_one
            assign st_r1 = st_r0;
            assign rk_r1 = rk_r0;
        end
    endgenerate

    // Next-state and datapath update.
    always_comb begin
        state_d      = state;
        key_loaded_d = key_loaded;
        key_reg_d    = key_reg;
        st_d         = st;
        rk_d         = rk;
        ct_d         = ct_q;
        ct_vld_d     = 1'b0;
        rnd_d        = rnd;
        case (state)
            IDLE: begin
                if (bus.kt_vld && kt_rdy_c) begin
                    key_reg_d    = bus.kt;
                    key_loaded_d = 1'b1;
                end
                if (bus.pt_vld && pt_rdy_c) begin
                    st_d    = bus.pt ^ key_reg;
                    rk_d    = key_reg;
                    rnd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d = st_r1;
                rk_d = rk_r1;
                if (rnd == RND_W'(NRC - 1)) begin
                    ct_d     = st_r1;
                    ct_vld_d = 1'b1;
                    rnd_d    = '0;
                    state_d  = IDLE;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_loaded <= 1'b0;
            key_reg    <= '0;
            st         <= '0;
            rk         <= '0;
            ct_q       <= '0;
            ct_vld_q   <= 1'b0;
            rnd        <= '0;
        end else begin
            state      <= state_d;
            key_loaded <= key_loaded_d;
            key_reg    <= key_reg_d;
            st         <= st_d;
            rk         <= rk_d;
            ct_q       <= ct_d;
            ct_vld_q   <= ct_vld_d;
            rnd        <= rnd_d;
        end
    end

endmodule

// File: tb/tb_aes_encrypt128_iter.sv
// Bench for aes_encrypt128_iter: one instance per ROUNDS_PER_CYCLE value,
// FIPS-197 vectors plus an independent byte-level AES reference model,
// scoreboard queues filled on plaintext accept and drained on ct_vld.
module tb_aes_encrypt128_iter;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] ct;
        int           acc;
        int           lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   ct_cnt1 = 0;
    int   ct_cnt2 = 0;
    sb_t  q1[$];
    sb_t  q2[$];
    sb_t  e1, e2;
    logic [7:0] ref_sb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt128_iter_if if1();
    aes_encrypt128_iter_if if2();

    aes_encrypt128_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    aes_encrypt128_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from GF inverse and affine map, independent of the RTL table.
    task automatic build_sbox();
        logic [7:0] inv, xb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            ref_sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] kb [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tw [4];
        logic [7:0] rc, tmp;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) kb[i] = key[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = kb[i-4+j];
            if (i % 16 == 0) begin
                tmp   = tw[0];
                tw[0] = ref_sb[tw[1]] ^ rc;
                tw[1] = ref_sb[tw[2]];
                tw[2] = ref_sb[tw[3]];
                tw[3] = ref_sb[tmp];
                rc    = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) kb[i+j] = kb[i-16+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ kb[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = ref_sb[s[i]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4*c+rr] = (r == 10) ? t[4*c+rr] :
                                gmul(8'h02, t[4*c+rr]) ^ gmul(8'h03, t[4*c+(rr+1)%4]) ^
                                t[4*c+(rr+2)%4] ^ t[4*c+(rr+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kb[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (if1.ct_vld === 1'b1) begin
            ct_cnt1++;
            if (q1.size() == 0) check("dut1_unexpected_ct_vld", 128'(1), 128'(0));
            else begin
                e1 = q1.pop_front();
                check("dut1_ct", if1.ct, e1.ct);
                check("dut1_latency", 128'(cyc - e1.acc), 128'(e1.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (if2.ct_vld === 1'b1) begin
            ct_cnt2++;
            if (q2.size() == 0) check("dut2_unexpected_ct_vld", 128'(1), 128'(0));
            else begin
                e2 = q2.pop_front();
                check("dut2_ct", if2.ct, e2.ct);
                check("dut2_latency", 128'(cyc - e2.acc), 128'(e2.lat));
            end
        end
    end

    // ---------------- dut1 driver tasks ----------------
    task automatic load_key1(input logic [127:0] k);
        int n;
        if1.kt = k;
        if1.kt_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (if1.kt_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("key_accept", 128'(if1.kt_rdy), 128'(1));
        @(posedge clk); #1;
        if1.kt_vld = 1'b0;
    endtask

    task automatic send_pt1(input logic [127:0] p, input logic [127:0] exp, input bit hold,
                            output int acc, output int waited);
        if1.pt = p;
        if1.pt_vld = 1'b1;
        waited = 0;
        @(negedge clk);
        while (if1.pt_rdy !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("pt_accept", 128'(if1.pt_rdy), 128'(1));
        acc = cyc;
        q1.push_back('{ct: exp, acc: cyc, lat: 11});
        @(posedge clk); #1;
        if (!hold) if1.pt_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(q1.size() + q2.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a1, a2, w, cnt, c0;
        logic [127:0] rk, rp;
        if1.kt = '0; if1.kt_vld = 1'b0; if1.pt = '0; if1.pt_vld = 1'b0;
        if2.kt = '0; if2.kt_vld = 1'b0; if2.pt = '0; if2.pt_vld = 1'b0;
        build_sbox();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ct", if1.ct, 128'(0));
        check("rst_ct_vld", 128'(if1.ct_vld), 128'(0));
        check("rst_kt_rdy", 128'(if1.kt_rdy), 128'(0));
        check("rst_pt_rdy", 128'(if1.pt_rdy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_kt_rdy", 128'(if1.kt_rdy), 128'(1));
        check("nokey_pt_rdy", 128'(if1.pt_rdy), 128'(0));

        // No key loaded: plaintext must wait
        @(posedge clk); #1;
        if1.pt = PA; if1.pt_vld = 1'b1;
        cnt = 0; c0 = ct_cnt1;
        repeat (50) begin
            @(negedge clk);
            if (if1.pt_rdy === 1'b1) cnt++;
        end
        check("nokey_pt_rdy_count", 128'(cnt), 128'(0));
        check("nokey_ct_vld_count", 128'(ct_cnt1 - c0), 128'(0));

        // Key and plaintext together: key first, plaintext next cycle (C.1)
        @(posedge clk); #1;
        if1.kt = KA; if1.kt_vld = 1'b1;
        @(negedge clk);
        check("prio_kt_rdy", 128'(if1.kt_rdy), 128'(1));
        check("prio_pt_rdy", 128'(if1.pt_rdy), 128'(0));
        @(posedge clk); #1;
        if1.kt_vld = 1'b0;
        send_pt1(PA, CA, 1'b0, a1, w);
        check("prio_pt_wait", 128'(w), 128'(0));
        wait_drain();

        // Appendix B on both instances
        load_key1(KB);
        send_pt1(PB, CB, 1'b0, a1, w);
        if2.kt = KB; if2.kt_vld = 1'b1;
        @(negedge clk);
        check("dut2_kt_rdy", 128'(if2.kt_rdy), 128'(1));
        @(posedge clk); #1;
        if2.kt_vld = 1'b0;
        if2.pt = PB; if2.pt_vld = 1'b1;
        @(negedge clk);
        check("dut2_pt_rdy", 128'(if2.pt_rdy), 128'(1));
        q2.push_back('{ct: CB, acc: cyc, lat: 6});
        @(posedge clk); #1;
        if2.pt_vld = 1'b0;
        wait_drain();

        // C.1 on the two-round instance
        if2.kt = KA; if2.kt_vld = 1'b1;
        @(posedge clk); #1;
        if2.kt_vld = 1'b0;
        if2.pt = PA; if2.pt_vld = 1'b1;
        @(negedge clk);
        check("dut2_pt_rdy_c1", 128'(if2.pt_rdy), 128'(1));
        q2.push_back('{ct: CA, acc: cyc, lat: 6});
        @(posedge clk); #1;
        if2.pt_vld = 1'b0;
        wait_drain();

        // Back-to-back under one key
        load_key1(KA);
        send_pt1(PA, CA, 1'b1, a1, w);
        send_pt1(PB, aes_ref(KA, PB), 1'b0, a2, w);
        check("b2b_gap", 128'(a2 - a1), 128'(11));
        wait_drain();

        // Key change requested mid-block
        send_pt1(PA, CA, 1'b0, a1, w);
        repeat (3) begin @(posedge clk); #1; end
        if1.kt = KB; if1.kt_vld = 1'b1;
        @(negedge clk);
        check("run_kt_rdy", 128'(if1.kt_rdy), 128'(0));
        check("run_pt_rdy", 128'(if1.pt_rdy), 128'(0));
        load_key1(KB);
        send_pt1(PB, CB, 1'b0, a1, w);
        wait_drain();

        // Random keys and blocks against the reference model
        repeat (3) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key1(rk);
            send_pt1(rp, aes_ref(rk, rp), 1'b0, a1, w);
            wait_drain();
        end

        // Reset in the middle of a block
        load_key1(KB);
        send_pt1(PB, CB, 1'b0, a1, w);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        q1.delete();
        @(negedge clk);
        check("midrst_kt_rdy", 128'(if1.kt_rdy), 128'(0));
        check("midrst_pt_rdy", 128'(if1.pt_rdy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = ct_cnt1;
        if1.pt = PA; if1.pt_vld = 1'b1;
        @(negedge clk);
        check("postrst_ct", if1.ct, 128'(0));
        check("postrst_kt_rdy", 128'(if1.kt_rdy), 128'(1));
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (if1.pt_rdy === 1'b1) cnt++;
        end
        check("postrst_pt_rdy_count", 128'(cnt), 128'(0));
        check("postrst_ct_vld_count", 128'(ct_cnt1 - c0), 128'(0));
        @(posedge clk); #1;
        load_key1(KA);
        send_pt1(PA, CA, 1'b0, a1, w);
        check("reload_pt_wait", 128'(w), 128'(0));
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
